// File: rtl/gpio_regfile_ctrl.sv
// Register-file controller bridging the MicroBlaze GPIO word pair to fabric control/status registers.
// Commands arrive on a toggle-handshaked GPO word; results and ack return on the GPI word.
module gpio_regfile_ctrl #(
    parameter int NB_GPIOS = 32,
    parameter int NB_REG   = 32,
    parameter int NB_CTRL  = 8,
    parameter int NB_STAT  = 4,
    parameter int NB_PULSE = 4
) (
    input  logic                       clockdsp,
    input  logic                       reset,
    input  logic [NB_GPIOS-1:0]        i_gpo,
    output logic [NB_GPIOS-1:0]        o_gpi,
    input  logic [NB_STAT*NB_REG-1:0]  i_status,
    output logic [NB_CTRL*NB_REG-1:0]  o_ctrl,
    output logic [NB_PULSE-1:0]        o_pulse,
    output logic                       o_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_WR_LO   = 3'd1;
    localparam logic [2:0] CMD_WR_HI   = 3'd2;
    localparam logic [2:0] CMD_RD_LO   = 3'd3;
    localparam logic [2:0] CMD_RD_HI   = 3'd4;
    localparam logic [2:0] CMD_PULSE   = 3'd5;
    localparam logic [2:0] CMD_CAPTURE = 3'd6;

    logic [1:0]           state_q, state_d;
    logic [NB_GPIOS-1:0]  gpo_q;
    logic [2:0]           cmd_q, cmd_d;
    logic [4:0]           addr_q, addr_d;
    logic [15:0]          data_q, data_d;
    logic                 stb_q, stb_d;
    logic [15:0]          stageLo_q, stageLo_d;
    logic [NB_REG-1:0]    ctrl_q [NB_CTRL];
    logic [NB_REG-1:0]    ctrl_d [NB_CTRL];
    logic [NB_REG-1:0]    snap_q [NB_STAT];
    logic [NB_REG-1:0]    snap_d [NB_STAT];
    logic                 err_q, err_d;
    logic [15:0]          rdata_q, rdata_d;
    logic [NB_GPIOS-1:0]  gpi_q, gpi_d;
    logic [NB_PULSE-1:0]  pulse_q, pulse_d;
    logic                 busy_q, busy_d;

    logic [NB_REG-1:0]    regWord;
    logic                 ctrlHit;
    logic                 statHit;
    logic                 pulseHit;
    logic [6:0]           unusedGpo;

    assign unusedGpo = gpo_q[22:16];

    // A command is pending whenever the registered strobe differs from the last returned ack.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        stb_d     = stb_q;
        stageLo_d = stageLo_q;
        ctrl_d    = ctrl_q;
        snap_d    = snap_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        gpi_d     = gpi_q;
        pulse_d   = '0;
        regWord   = '0;
        ctrlHit   = 1'b0;
        statHit   = 1'b0;
        pulseHit  = 1'b0;

        for (int k = 0; k < NB_CTRL; k++) begin
            if (addr_q == 5'(k)) begin
                ctrlHit = 1'b1;
                regWord = ctrl_q[k];
            end
        end
        for (int k = 0; k < NB_STAT; k++) begin
            if (addr_q == 5'(NB_CTRL + k)) begin
                statHit = 1'b1;
                regWord = snap_q[k];
            end
        end

        case (state_q)
            IDLE: begin
                if (gpo_q[28] != gpi_q[31]) begin
                    cmd_d   = gpo_q[31:29];
                    addr_d  = gpo_q[27:23];
                    data_d  = gpo_q[15:0];
                    stb_d   = gpo_q[28];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                err_d   = 1'b0;
                rdata_d = '0;
                state_d = ACK;
                case (cmd_q)
                    CMD_NOP: ;
                    CMD_WR_LO: stageLo_d = data_q;
                    CMD_WR_HI: begin
                        if (ctrlHit) begin
                            for (int k = 0; k < NB_CTRL; k++) begin
                                if (addr_q == 5'(k)) ctrl_d[k] = {data_q, stageLo_q};
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    CMD_RD_LO: begin
                        if (ctrlHit || statHit) rdata_d = regWord[15:0];
                        else                    err_d   = 1'b1;
                    end
                    CMD_RD_HI: begin
                        if (ctrlHit || statHit) rdata_d = regWord[NB_REG-1:16];
                        else                    err_d   = 1'b1;
                    end
                    CMD_PULSE: begin
                        for (int k = 0; k < NB_PULSE; k++) begin
                            if (addr_q == 5'(k)) begin
                                pulse_d[k] = 1'b1;
                                pulseHit   = 1'b1;
                            end
                        end
                        if (!pulseHit) err_d = 1'b1;
                    end
                    CMD_CAPTURE: begin
                        for (int k = 0; k < NB_STAT; k++) snap_d[k] = i_status[k*NB_REG +: NB_REG];
                    end
                    default: err_d = 1'b1;
                endcase
            end
            ACK: begin
                gpi_d   = {stb_q, err_q, {(NB_GPIOS-18){1'b0}}, rdata_q};
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clockdsp) begin
        if (reset) begin
            state_q   <= IDLE;
            gpo_q     <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            stb_q     <= 1'b0;
            stageLo_q <= '0;
            for (int k = 0; k < NB_CTRL; k++) ctrl_q[k] <= '0;
            for (int k = 0; k < NB_STAT; k++) snap_q[k] <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            gpi_q     <= '0;
            pulse_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gpo_q     <= i_gpo;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            stb_q     <= stb_d;
            stageLo_q <= stageLo_d;
            ctrl_q    <= ctrl_d;
            snap_q    <= snap_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            gpi_q     <= gpi_d;
            pulse_q   <= pulse_d;
            busy_q    <= busy_d;
        end
    end

    for (genvar g = 0; g < NB_CTRL; g++) begin : g_ctrl
        assign o_ctrl[g*NB_REG +: NB_REG] = ctrl_q[g];
    end

    assign o_gpi   = gpi_q;
    assign o_pulse = pulse_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_gpio_regfile_ctrl.sv
// Directed scoreboard bench for gpio_regfile_ctrl: expected GPI words are queued when a command is
// driven and compared when the ack returns; control bank, pulses and busy are checked alongside.
module tb_gpio_regfile_ctrl;

    localparam int NB_CTRL  = 8;
    localparam int NB_STAT  = 4;
    localparam int NB_PULSE = 4;

    localparam logic [2:0] NOP = 3'd0, WR_LO = 3'd1, WR_HI = 3'd2, RD_LO = 3'd3;
    localparam logic [2:0] RD_HI = 3'd4, PULSE = 3'd5, CAPTURE = 3'd6, ILLEGAL = 3'd7;

    logic          clockdsp = 1'b0;
    logic          reset;
    logic [31:0]   i_gpo;
    logic [31:0]   o_gpi;
    logic [127:0]  i_status;
    logic [255:0]  o_ctrl;
    logic [3:0]    o_pulse;
    logic          o_busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] expQ [$];
    logic [31:0] mCtrl [NB_CTRL];
    logic [31:0] mSnap [NB_STAT];
    logic [15:0] mStage;
    logic        stb;

    gpio_regfile_ctrl dut (
        .clockdsp (clockdsp),
        .reset    (reset),
        .i_gpo    (i_gpo),
        .o_gpi    (o_gpi),
        .i_status (i_status),
        .o_ctrl   (o_ctrl),
        .o_pulse  (o_pulse),
        .o_busy   (o_busy)
    );

    always #5 clockdsp = ~clockdsp;

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] packCtrl();
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < NB_CTRL; k++) r[k*32 +: 32] = mCtrl[k];
        return r;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < NB_CTRL; k++) mCtrl[k] = '0;
        for (int k = 0; k < NB_STAT; k++) mSnap[k] = '0;
        mStage = '0;
        stb    = 1'b0;
    endtask

    // Drives one command, predicts its GPI word, then waits (bounded) for the matching ack.
    task automatic applyStimulus(input logic [2:0] cmd, input logic [4:0] addr, input logic [15:0] data,
                                 input string tag);
        logic        err;
        logic [15:0] rd;
        logic [3:0]  expPulse;
        logic [31:0] regW;
        logic        hit;
        logic [31:0] exp;
        logic [3:0]  pulseSeen;
        int          pulseCycles;
        int          lat;

        @(negedge clockdsp);
        stb   = ~stb;
        i_gpo = {cmd, stb, addr, 7'b0, data};

        err = 1'b0; rd = '0; expPulse = '0; regW = '0; hit = 1'b0;
        for (int k = 0; k < NB_CTRL; k++)
            if (addr == 5'(k)) begin hit = 1'b1; regW = mCtrl[k]; end
        for (int k = 0; k < NB_STAT; k++)
            if (addr == 5'(NB_CTRL + k)) begin hit = 1'b1; regW = mSnap[k]; end
        case (cmd)
            WR_LO: mStage = data;
            WR_HI: begin
                if (addr < 5'(NB_CTRL)) begin
                    for (int k = 0; k < NB_CTRL; k++)
                        if (addr == 5'(k)) mCtrl[k] = {data, mStage};
                end else err = 1'b1;
            end
            RD_LO: if (hit) rd = regW[15:0];  else err = 1'b1;
            RD_HI: if (hit) rd = regW[31:16]; else err = 1'b1;
            PULSE: begin
                if (addr < 5'(NB_PULSE)) begin
                    for (int k = 0; k < NB_PULSE; k++)
                        if (addr == 5'(k)) expPulse[k] = 1'b1;
                end else err = 1'b1;
            end
            CAPTURE: for (int k = 0; k < NB_STAT; k++) mSnap[k] = i_status[k*32 +: 32];
            ILLEGAL: err = 1'b1;
            default: ;
        endcase
        expQ.push_back({stb, err, 14'b0, rd});

        lat = 0; pulseSeen = '0; pulseCycles = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clockdsp);
            #1;
            if (o_pulse != 4'b0) begin
                pulseSeen |= o_pulse;
                pulseCycles++;
            end
            if (o_gpi[31] === stb) begin
                lat = n;
                break;
            end
        end

        exp = expQ.pop_front();
        checkOutput({tag, "_latency"}, 256'(lat - 1), 256'(3));
        checkOutput({tag, "_gpi"}, 256'(o_gpi), 256'(exp));
        checkOutput({tag, "_pulse"}, 256'(pulseSeen), 256'(expPulse));
        checkOutput({tag, "_pulseCycles"}, 256'(pulseCycles), 256'((expPulse != 4'b0) ? 1 : 0));
        checkOutput({tag, "_ctrl"}, o_ctrl, packCtrl());
        checkOutput({tag, "_busy"}, 256'(o_busy), 256'(0));
    endtask

    initial begin
        logic [31:0] held;
        logic        busyAcc;

        reset    = 1'b1;
        i_gpo    = '0;
        i_status = '0;
        modelReset();

        // T1: reset state and quiet hold
        repeat (5) @(posedge clockdsp);
        @(negedge clockdsp);
        checkOutput("rst_ctrl",  o_ctrl, 256'(0));
        checkOutput("rst_gpi",   256'(o_gpi), 256'(0));
        checkOutput("rst_pulse", 256'(o_pulse), 256'(0));
        checkOutput("rst_busy",  256'(o_busy), 256'(0));
        reset = 1'b0;
        busyAcc = 1'b0;
        repeat (6) begin
            @(negedge clockdsp);
            busyAcc |= o_busy | (|o_pulse) | (|o_gpi);
        end
        checkOutput("idle_hold_activity", 256'(busyAcc), 256'(0));

        // T2: two-half write
        applyStimulus(WR_LO, 5'd0, 16'hBEEF, "t2_wrlo");
        checkOutput("t2_ctrl2_before", 256'(o_ctrl[95:64]), 256'(0));
        applyStimulus(WR_HI, 5'd2, 16'hDEAD, "t2_wrhi");
        checkOutput("t2_ctrl2_after", 256'(o_ctrl[95:64]), 256'(32'hDEAD_BEEF));

        // T3: reads back
        applyStimulus(RD_HI, 5'd2, 16'h0, "t3_rdhi");
        checkOutput("t3_rdhi_const", 256'(o_gpi), 256'(32'h8000_DEAD));
        applyStimulus(RD_LO, 5'd2, 16'h0, "t3_rdlo");
        checkOutput("t3_rdlo_const", 256'(o_gpi), 256'(32'h0000_BEEF));

        // T4: atomic status capture
        i_status[31:0]  = 32'h1234_5678;
        i_status[127:96] = 32'hCAFE_F00D;
        applyStimulus(CAPTURE, 5'd0, 16'h0, "t4_capture");
        i_status = '0;
        applyStimulus(RD_LO, 5'd8, 16'h0, "t4_rdlo8");
        checkOutput("t4_rdlo8_const", 256'(o_gpi[15:0]), 256'(16'h5678));
        applyStimulus(RD_HI, 5'd8, 16'h0, "t4_rdhi8");
        checkOutput("t4_rdhi8_const", 256'(o_gpi[15:0]), 256'(16'h1234));
        applyStimulus(RD_HI, 5'd11, 16'h0, "t4_rdhi11");

        // Boundary addresses and another write pattern
        applyStimulus(WR_LO, 5'd31, 16'h0001, "b_wrlo");
        applyStimulus(WR_HI, 5'd7, 16'hA5A5, "b_wrhi7");
        applyStimulus(RD_LO, 5'd7, 16'h0, "b_rdlo7");
        applyStimulus(RD_LO, 5'd12, 16'h0, "b_rdlo12");
        applyStimulus(RD_HI, 5'd20, 16'h0, "b_rdhi20");
        applyStimulus(WR_HI, 5'd8, 16'h1111, "b_wrhi8");

        // T5: error commands and pulses
        applyStimulus(ILLEGAL, 5'd1, 16'hFFFF, "t5_illegal");
        applyStimulus(WR_HI, 5'd9, 16'h5555, "t5_wrhi9");
        applyStimulus(PULSE, 5'd5, 16'h0, "t5_pulse5");
        applyStimulus(PULSE, 5'd1, 16'h0, "t5_pulse1");
        applyStimulus(PULSE, 5'd3, 16'h0, "t5_pulse3");
        applyStimulus(PULSE, 5'd4, 16'h0, "t5_pulse4");
        applyStimulus(NOP, 5'd0, 16'h1234, "t5_nop");

        // T6a: strobe toggled twice while busy is dropped
        @(negedge clockdsp);
        stb   = ~stb;
        i_gpo = {NOP, stb, 5'd0, 7'b0, 16'h0};
        expQ.push_back({stb, 1'b0, 30'b0});
        @(posedge clockdsp);
        @(posedge clockdsp);
        @(negedge clockdsp);
        i_gpo[28] = ~stb;
        @(negedge clockdsp);
        i_gpo[28] = stb;
        @(posedge clockdsp);
        #1;
        held = expQ.pop_front();
        checkOutput("t6_first_ack", 256'(o_gpi), 256'(held));
        busyAcc = 1'b0;
        repeat (8) begin
            @(posedge clockdsp);
            #1;
            busyAcc |= o_busy;
        end
        checkOutput("t6_dropped_busy", 256'(busyAcc), 256'(0));
        checkOutput("t6_dropped_gpi", 256'(o_gpi), 256'(held));

        // T6b: reset during EXEC of a WR_HI
        applyStimulus(WR_LO, 5'd0, 16'h2222, "t6_wrlo");
        @(negedge clockdsp);
        stb   = ~stb;
        i_gpo = {WR_HI, stb, 5'd3, 7'b0, 16'h3333};
        @(posedge clockdsp);
        @(posedge clockdsp);
        @(negedge clockdsp);
        checkOutput("t6_busy_in_exec", 256'(o_busy), 256'(1));
        reset = 1'b1;
        i_gpo = '0;
        repeat (2) @(posedge clockdsp);
        @(negedge clockdsp);
        reset = 1'b0;
        modelReset();
        repeat (4) @(negedge clockdsp);
        checkOutput("t6_rst_ctrl", o_ctrl, 256'(0));
        checkOutput("t6_rst_gpi",  256'(o_gpi), 256'(0));
        checkOutput("t6_rst_busy", 256'(o_busy), 256'(0));

        // Recovery after abort
        applyStimulus(WR_LO, 5'd0, 16'h4444, "rec_wrlo");
        applyStimulus(WR_HI, 5'd3, 16'h5555, "rec_wrhi3");
        checkOutput("rec_ctrl3", 256'(o_ctrl[127:96]), 256'(32'h5555_4444));
        applyStimulus(RD_HI, 5'd3, 16'h0, "rec_rdhi3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
